// File: rtl/spi_slave_dx.sv
// Full-duplex SPI slave: oversampled mcs/sclk/mosi, tx holding register, valid/ready rx/tx words.
// Optional rx FIFO enabled by defining SPI_SLV_RX_FIFO_EN; otherwise a single rx output register.
module spi_slave_dx #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter bit          MCS_VALID_LEVEL = 1'b0,
  parameter logic [1:0]  SCK_MODE        = 2'b01,
  parameter bit          DATA_ENDIAN     = 1'b1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned RX_FIFO_DEPTH   = 4
) (
  input  logic                  mclk,
  input  logic                  mrst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_rx_ovf,
  output logic                  o_tx_udf,
  output logic                  o_abort,
  output logic                  o_busy,
  input  logic                  mcs,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  o_miso_oe
);
  localparam int unsigned CW   = $clog2(DATA_WIDTH);
  localparam bit          CPOL = SCK_MODE[1];
  localparam bit          CPHA = SCK_MODE[0];

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  mcs_sync, sclk_sync, mosi_sync;
  logic                    sclk_d;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   rx_shift, tx_shift, tx_shift_nx, tx_hold;
  logic                    hold_full, hold_full_nx, tx_ready, udf, udf_pend, abort, busy, miso_q, oe;
  logic                    rx_valid, rx_ovf;

  // Input synchronisers; reset to the idle levels so no spurious edge appears on release
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      mcs_sync  <= {SYNC_STAGES{~MCS_VALID_LEVEL}};
      sclk_sync <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      sclk_d    <= CPOL;
    end else begin
      mcs_sync  <= {mcs_sync[SYNC_STAGES-2:0], mcs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic mcs_on, sclk_s, mosi_s, lead_edge, trail_edge, sample_edge, shift_edge;
  logic load, tx_take, word_done, rx_pop;
  logic [DATA_WIDTH-1:0] rx_word;

  assign mcs_on      = (mcs_sync[SYNC_STAGES-1] == MCS_VALID_LEVEL);
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_s != sclk_d) && (sclk_d == CPOL);
  assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign load        = (state == LOAD) && mcs_on;
  assign tx_take     = i_tx_valid && tx_ready;
  assign word_done   = (state == SHIFT) && mcs_on && sample_edge && (bit_cnt == CW'(DATA_WIDTH - 1));
  assign rx_pop      = rx_valid && i_rx_ready;
  assign rx_word     = DATA_ENDIAN ? {rx_shift[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_shift[DATA_WIDTH-1:1]};

  // A shift edge before any sample of the current word is skipped: it is either the CPHA=1
  // leading edge that presents bit 0, or the CPHA=0 trailing edge that closed the previous word.
  always_comb begin
    tx_shift_nx  = tx_shift;
    hold_full_nx = hold_full;
    if (load) begin
      tx_shift_nx = hold_full ? tx_hold : (tx_take ? i_tx_data : '0);
      if (hold_full) hold_full_nx = 1'b0;
    end else begin
      if (tx_take) hold_full_nx = 1'b1;
      if ((state == SHIFT) && mcs_on && shift_edge && (bit_cnt != '0))
        tx_shift_nx = DATA_ENDIAN ? {tx_shift[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_shift[DATA_WIDTH-1:1]};
    end
  end

  // Frame FSM, tx path and status flags. Underflow is reported when the zero-filled word actually
  // starts on the wire, so the speculative load after a frame's last word never flags.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_hold   <= '0;
      hold_full <= 1'b0;
      tx_ready  <= 1'b0;
      udf       <= 1'b0;
      udf_pend  <= 1'b0;
      abort     <= 1'b0;
      busy      <= 1'b0;
      miso_q    <= 1'b0;
      oe        <= 1'b0;
    end else begin
      tx_shift  <= tx_shift_nx;
      hold_full <= hold_full_nx;
      tx_ready  <= ~hold_full_nx;
      if (tx_take && !load) tx_hold <= i_tx_data;
      udf    <= 1'b0;
      abort  <= 1'b0;
      busy   <= mcs_on;
      oe     <= mcs_on;
      miso_q <= (mcs_on && (state != IDLE)) ?
                (DATA_ENDIAN ? tx_shift_nx[DATA_WIDTH-1] : tx_shift_nx[0]) : 1'b0;
      if (!mcs_on) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        udf_pend <= 1'b0;
        abort    <= (state == SHIFT) && (bit_cnt != '0);
      end else begin
        case (state)
          IDLE: state <= LOAD;
          LOAD: begin
            udf_pend <= !hold_full && !tx_take;
            state    <= SHIFT;
          end
          SHIFT: if (sample_edge) begin
            rx_shift <= rx_word;
            if (bit_cnt == '0 && udf_pend) begin
              udf      <= 1'b1;
              udf_pend <= 1'b0;
            end
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= LOAD;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_SLV_RX_FIFO_EN
  localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic                  full, push;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = word_done && (!full || rx_pop);
  assign wr_nx = wr_ptr + (AW+1)'(push);
  assign rd_nx = rd_ptr + (AW+1)'(rx_pop);

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_valid <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      wr_ptr   <= wr_nx;
      rd_ptr   <= rd_nx;
      rx_valid <= (wr_nx != rd_nx);
      rx_ovf   <= word_done && !push;
    end
  end

  always_ff @(posedge mclk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= rx_word;
  end

  assign o_rx_data = rx_valid ? fifo_mem[rd_ptr[AW-1:0]] : '0;
`else
  logic [DATA_WIDTH-1:0] rx_data;

  // Single output register: a word completing while the previous one is still unread is dropped
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      rx_ovf <= word_done && rx_valid && !rx_pop;
      if (word_done && (!rx_valid || rx_pop)) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data = rx_data;
`endif

  assign o_rx_valid = rx_valid;
  assign o_rx_ovf   = rx_ovf;
  assign o_tx_ready = tx_ready;
  assign o_tx_udf   = udf;
  assign o_abort    = abort;
  assign o_busy     = busy;
  assign miso       = miso_q;
  assign o_miso_oe  = oe;

endmodule

// File: tb/tb_spi_slave_dx.sv
// Scoreboard bench for spi_slave_dx: one W=16 mode-0 MSB-first slave plus four W=8 LSB-first
// slaves (one per SCK_MODE) sharing a bit-banged SPI master.
module tb_spi_slave_dx;
  localparam int H = 8;  // sclk half period in mclk cycles

  logic        mclk, mrst;
  logic        sclk_raw, mosi, mcs_m;
  int          sel;
  logic [4:0]  mcs_v, sclk_v, miso_v, oe_v, tx_ready_v, tx_valid_v, rx_valid_v, rx_ready_v;
  logic [4:0]  ovf_v, udf_v, abort_v, busy_v;
  logic [15:0] tx_data0;
  logic [7:0]  tx_data8;
  logic [4:0][15:0] rx_data_a;

  logic [15:0] rx_exp [5][$];
  logic [15:0] mo_words [3];
  logic [15:0] miso_got [3];
  int          udf_cnt [5];
  int          ovf_cnt [5];
  int          abort_cnt [5];
  int          compares, fails;

  spi_slave_dx #(.DATA_WIDTH(16), .SCK_MODE(2'b00), .DATA_ENDIAN(1'b1)) u_dut0 (
    .mclk(mclk), .mrst(mrst), .i_tx_data(tx_data0), .i_tx_valid(tx_valid_v[0]), .o_tx_ready(tx_ready_v[0]),
    .o_rx_data(rx_data_a[0]), .o_rx_valid(rx_valid_v[0]), .i_rx_ready(rx_ready_v[0]), .o_rx_ovf(ovf_v[0]),
    .o_tx_udf(udf_v[0]), .o_abort(abort_v[0]), .o_busy(busy_v[0]), .mcs(mcs_v[0]), .sclk(sclk_v[0]),
    .mosi(mosi), .miso(miso_v[0]), .o_miso_oe(oe_v[0]));

  for (genvar g = 1; g < 5; g++) begin : g_dut8
    logic [7:0] rd8;
    spi_slave_dx #(.DATA_WIDTH(8), .SCK_MODE(2'(g - 1)), .DATA_ENDIAN(1'b0)) u_dut (
      .mclk(mclk), .mrst(mrst), .i_tx_data(tx_data8), .i_tx_valid(tx_valid_v[g]), .o_tx_ready(tx_ready_v[g]),
      .o_rx_data(rd8), .o_rx_valid(rx_valid_v[g]), .i_rx_ready(rx_ready_v[g]), .o_rx_ovf(ovf_v[g]),
      .o_tx_udf(udf_v[g]), .o_abort(abort_v[g]), .o_busy(busy_v[g]), .mcs(mcs_v[g]), .sclk(sclk_v[g]),
      .mosi(mosi), .miso(miso_v[g]), .o_miso_oe(oe_v[g]));
    assign rx_data_a[g] = {8'h00, rd8};
  end

  // Slave k sees the master's chip select only when selected; sclk idles at its own CPOL
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      mcs_v[k]  = (sel == k) ? mcs_m : 1'b1;
      sclk_v[k] = sclk_raw ^ ((k >= 3) ? 1'b1 : 1'b0);
    end
  end

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever a slave hands over a word
  always @(negedge mclk) begin
    for (int k = 0; k < 5; k++) begin
      if (!mrst && rx_valid_v[k] && rx_ready_v[k]) begin
        compares++;
        if (rx_exp[k].size() == 0) begin
          fails++;
          $display("FAIL rx_unexpected dut%0d: got %0h expected no word", k, rx_data_a[k]);
        end else begin
          logic [15:0] e;
          e = rx_exp[k].pop_front();
          if (rx_data_a[k] !== e) begin
            fails++;
            $display("FAIL rx_data dut%0d: got %0h expected %0h", k, rx_data_a[k], e);
          end
        end
      end
      if (udf_v[k])   udf_cnt[k]++;
      if (ovf_v[k])   ovf_cnt[k]++;
      if (abort_v[k]) abort_cnt[k]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic clr_flags();
    for (int k = 0; k < 5; k++) begin
      udf_cnt[k] = 0; ovf_cnt[k] = 0; abort_cnt[k] = 0;
    end
  endtask

  task automatic push_tx(input int k, input logic [15:0] d);
    int t;
    t = 0;
    @(negedge mclk);
    while (!tx_ready_v[k] && t < 200) begin
      @(negedge mclk);
      t++;
    end
    chk("tx_ready_wait", 32'(tx_ready_v[k]), 32'd1);
    if (k == 0) tx_data0 = d; else tx_data8 = d[7:0];
    tx_valid_v[k] = 1'b1;
    @(posedge mclk);
    #1 tx_valid_v[k] = 1'b0;
  endtask

  // Master frame of nw words; stop_bits>0 deasserts mcs after that many bits of the first word
  task automatic frame(input int k, input int w, input bit cpha, input bit msb, input int nw, input int stop_bits);
    int idx;
    logic [15:0] cap;
    sel = k;
    cyc(2);
    mcs_m = 1'b0;
    cyc(2 * H);
    for (int n = 0; n < nw; n++) begin
      cap = '0;
      for (int b = 0; b < w; b++) begin
        if (stop_bits > 0 && b == stop_bits) break;
        idx = msb ? (w - 1 - b) : b;
        if (!cpha) begin
          mosi = mo_words[n][idx];
          cyc(H);
          cap[idx] = miso_v[k];
          sclk_raw = 1'b1;
          cyc(H);
          sclk_raw = 1'b0;
        end else begin
          sclk_raw = 1'b1;
          mosi = mo_words[n][idx];
          cyc(H);
          cap[idx] = miso_v[k];
          sclk_raw = 1'b0;
          cyc(H);
        end
      end
      miso_got[n] = cap;
    end
    cyc(2 * H);
    mcs_m = 1'b1;
    cyc(4 * H);
  endtask

  initial begin
    compares = 0; fails = 0;
    mrst = 1'b1; sclk_raw = 1'b0; mosi = 1'b0; mcs_m = 1'b1; sel = 0;
    tx_valid_v = '0; rx_ready_v = '1; tx_data0 = '0; tx_data8 = '0;
    clr_flags();

    // Reset state
    cyc(4);
    @(negedge mclk);
    chk("rst_tx_ready", 32'(tx_ready_v[0]), 32'd0);
    chk("rst_outputs", 32'({rx_valid_v[0], busy_v[0], oe_v[0], miso_v[0]}), 32'd0);
    mrst = 1'b0;
    @(negedge mclk);
    chk("tx_ready_after_release", 32'(tx_ready_v), 32'h1f);

    // 1: mode 0, MSB first; a follow-on word keeps the speculative end-of-word load from underflowing
    push_tx(0, 16'hA55A);
    cyc(2);
    clr_flags();
    mo_words[0] = 16'h1234;
    rx_exp[0].push_back(16'h1234);
    fork
      frame(0, 16, 1'b0, 1'b1, 1, 0);
      begin cyc(40); push_tx(0, 16'h0000); end
    join
    chk("t1_miso", 32'(miso_got[0]), 32'hA55A);
    chk("t1_flags", 32'(udf_cnt[0] + ovf_cnt[0] + abort_cnt[0]), 32'd0);

    // 2: all four clock modes, W=8, LSB first
    for (int k = 1; k < 5; k++) begin
      clr_flags();
      push_tx(k, 16'h003C);
      mo_words[0] = 16'h0081;
      rx_exp[k].push_back(16'h0081);
      frame(k, 8, 1'((k - 1) & 1), 1'b0, 1, 0);
      chk($sformatf("t2_miso_mode%0d", k - 1), 32'(miso_got[0][7:0]), 32'h3C);
      chk($sformatf("t2_udf_mode%0d", k - 1), 32'(udf_cnt[k]), 32'd0);
    end

    // 3: three back-to-back words with only the first preloaded
    clr_flags();
    push_tx(0, 16'hC3E1);
    mo_words[0] = 16'h0001; mo_words[1] = 16'h0002; mo_words[2] = 16'h0003;
    for (int n = 1; n <= 3; n++) rx_exp[0].push_back(16'(n));
    frame(0, 16, 1'b0, 1'b1, 3, 0);
    chk("t3_miso_w1", 32'(miso_got[0]), 32'hC3E1);
    chk("t3_miso_w2", 32'(miso_got[1]), 32'h0000);
    chk("t3_miso_w3", 32'(miso_got[2]), 32'h0000);
    chk("t3_udf_count", 32'(udf_cnt[0]), 32'd2);
    chk("t3_abort", 32'(abort_cnt[0]), 32'd0);

    // 4: rx stalled while two words arrive
    rx_ready_v[0] = 1'b0;
    clr_flags();
    mo_words[0] = 16'hBEEF; mo_words[1] = 16'h0F0F;
    rx_exp[0].push_back(16'hBEEF);
`ifdef SPI_SLV_RX_FIFO_EN
    rx_exp[0].push_back(16'h0F0F);
`endif
    frame(0, 16, 1'b0, 1'b1, 2, 0);
    @(negedge mclk);
    chk("t4_rx_valid_held", 32'(rx_valid_v[0]), 32'd1);
    chk("t4_rx_data_held", 32'(rx_data_a[0]), 32'hBEEF);
`ifdef SPI_SLV_RX_FIFO_EN
    chk("t4_ovf_count", 32'(ovf_cnt[0]), 32'd0);
`else
    chk("t4_ovf_count", 32'(ovf_cnt[0]), 32'd1);
`endif
    cyc(1);
    rx_ready_v[0] = 1'b1;
    cyc(8);
    chk("t4_rx_drained", 32'(rx_valid_v[0]), 32'd0);

    // 5: chip select dropped after 5 bits, then a clean frame
    clr_flags();
    mo_words[0] = 16'hFFFF;
    frame(0, 16, 1'b0, 1'b1, 1, 5);
    chk("t5_abort_count", 32'(abort_cnt[0]), 32'd1);
    clr_flags();
    push_tx(0, 16'h7E81);
    mo_words[0] = 16'h5A5A;
    rx_exp[0].push_back(16'h5A5A);
    frame(0, 16, 1'b0, 1'b1, 1, 0);
    chk("t5_miso_after", 32'(miso_got[0]), 32'h7E81);
    chk("t5_abort_after", 32'(abort_cnt[0]), 32'd0);

    // 6: reset in the middle of a word
    sel = 0;
    cyc(2);
    mcs_m = 1'b0;
    cyc(2 * H);
    for (int b = 0; b < 6; b++) begin
      mosi = b[0];
      cyc(H);
      sclk_raw = 1'b1;
      cyc(H);
      sclk_raw = 1'b0;
    end
    chk("t6_busy_before", 32'(busy_v[0]), 32'd1);
    @(posedge mclk);
    #3 mrst = 1'b1;
    #1;
    chk("t6_flags_regs_zero",
        32'({tx_ready_v[0], rx_valid_v[0], busy_v[0], oe_v[0], miso_v[0], ovf_v[0], udf_v[0], abort_v[0]}), 32'd0);
    chk("t6_rx_data_zero", 32'(rx_data_a[0]), 32'd0);
    mcs_m = 1'b1;
    cyc(4);
    @(negedge mclk);
    mrst = 1'b0;
    @(negedge mclk);
    chk("t6_tx_ready_release", 32'(tx_ready_v[0]), 32'd1);
    clr_flags();
    push_tx(0, 16'h0FF0);
    mo_words[0] = 16'h9669;
    rx_exp[0].push_back(16'h9669);
    frame(0, 16, 1'b0, 1'b1, 1, 0);
    chk("t6_miso_post_reset", 32'(miso_got[0]), 32'h0FF0);
    chk("t6_abort_post_reset", 32'(abort_cnt[0]), 32'd0);

    cyc(10);
    for (int k = 0; k < 5; k++) chk($sformatf("scoreboard_empty_dut%0d", k), 32'(rx_exp[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
